uart_tx_arbiter: RTL

Round-robin controller that shares a single UART transmitter (`fsm` control + serializer/parity/mux datapath) between `NUM_REQ` byte producers. It picks one pending requester, launches its byte with a single-cycle `data_valid` pulse, and follows the transmitter's `busy` through the frame. It then reports completion to the owner and re-arbitrates. It sits between the system's message sources (register readback, status reporter, debug echo, ...) and the UART TX top.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/uart_tx_rr_pick.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared state encoding and reset helpers for the round-robin UART TX arbiter.
package uart_arb_pkg;

    typedef enum bit [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    // The "last served" pointer resets to the top index so requester 0 wins first.
    function automatic int last_rst_value(input int num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin pick: first set req bit scanning upward from last+1, wrapping.
module uart_tx_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    last,
    output logic               found,
    output logic [IDXW-1:0]    idx
);

    localparam logic [IDXW:0] N_W = (IDXW+1)'(NUM_REQ);

    logic [IDXW-1:0]    w_cand [NUM_REQ];
    logic [NUM_REQ-1:0] w_hit;

    // Candidate gi is the (gi+1)-th index after last; one subtraction suffices to wrap.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [IDXW:0] w_sum;
        logic [IDXW:0] w_wrap;
        assign w_sum      = {1'b0, last} + (IDXW+1)'(gi + 1);
        assign w_wrap     = (w_sum >= N_W) ? (w_sum - N_W) : w_sum;
        assign w_cand[gi] = w_wrap[IDXW-1:0];
        assign w_hit[gi]  = req[w_cand[gi]];
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                found = 1'b1;
                idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional wait-state watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    input  logic                          tx_busy,
    output logic                          arb_busy,
    output logic                          timeout_err
);

    localparam int              IDXW     = $clog2(NUM_REQ);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(last_rst_value(NUM_REQ));
    localparam int              unused_timeout_cycles = TIMEOUT_CYCLES;

    arb_state_e r_state;
    arb_state_e w_state_next;

    logic [IDXW-1:0]       r_owner;
    logic [IDXW-1:0]       r_last;
    logic [IDXW-1:0]       w_pick_idx;
    logic                  w_pick_found;
    logic                  w_capture;
    logic                  w_expire;
    logic                  w_timeout_fire;
    logic [DATA_WIDTH-1:0] w_bytes [NUM_REQ];
    logic [DATA_WIDTH-1:0] r_data;

    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] w_gnt_next;
    logic [NUM_REQ-1:0] w_done_next;
    logic               r_valid;
    logic               r_arb_busy;
    logic               r_timeout;
    logic               w_valid_next;
    logic               w_arb_busy_next;
    logic               w_timeout_next;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign w_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_tx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .req   (req),
        .last  (r_last),
        .found (w_pick_found),
        .idx   (w_pick_idx)
    );

    assign w_capture = (r_state == IDLE) && w_pick_found;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_wait_cnt;
    logic          w_in_wait;
    logic          w_enter_wait;

    assign w_in_wait    = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
    assign w_enter_wait = (w_state_next != r_state) &&
                          ((w_state_next == WAIT_BUSY) || (w_state_next == WAIT_DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (w_enter_wait) begin
            r_wait_cnt <= '0;
        end else if (w_in_wait) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Count value C_LIMIT marks the last permitted cycle in the wait state.
    assign w_expire = w_in_wait && (r_wait_cnt == C_LIMIT);
`else
    assign w_expire = 1'b0;
`endif

    // A normal busy transition always takes precedence over an expiring watchdog.
    assign w_timeout_fire = w_expire &&
                            (((r_state == WAIT_BUSY) && !tx_busy) ||
                             ((r_state == WAIT_DONE) &&  tx_busy));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_last     <= LAST_RST;
            r_data     <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_valid    <= 1'b0;
            r_arb_busy <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_owner <= w_pick_idx;
                r_last  <= w_pick_idx;
                r_data  <= w_bytes[w_pick_idx];
            end
            r_gnt      <= w_gnt_next;
            r_done     <= w_done_next;
            r_valid    <= w_valid_next;
            r_arb_busy <= w_arb_busy_next;
            r_timeout  <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_found) w_state_next = LAUNCH;
            end
            LAUNCH: begin
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy)       w_state_next = WAIT_DONE;
                else if (w_expire) w_state_next = IDLE;
            end
            WAIT_DONE: begin
                if (!tx_busy || w_expire) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are computed for the upcoming state so every port comes straight from a flop.
    always_comb begin
        w_gnt_next      = '0;
        w_done_next     = '0;
        w_valid_next    = 1'b0;
        w_arb_busy_next = (w_state_next != IDLE);
        w_timeout_next  = w_timeout_fire;
        if (w_capture) begin
            w_gnt_next[w_pick_idx] = 1'b1;
            w_valid_next           = 1'b1;
        end
        if ((r_state == WAIT_DONE) && !tx_busy) begin
            w_done_next[r_owner] = 1'b1;
        end
    end

    assign gnt           = r_gnt;
    assign done          = r_done;
    assign tx_data_valid = r_valid;
    assign tx_p_data     = r_data;
    assign arb_busy      = r_arb_busy;
    assign timeout_err   = r_timeout;

endmodule
